// File: rtl/probe_result_packer_if.sv
// Bundle of the issue, per-lane result and output streams of probe_result_packer.
//   iss_*         : one issue record per probe word sent by the splitter (mask, last)
//   res_*         : eight result lanes (payload, hit flag, {lane, serial number})
//   out_*         : packed 512-bit output word stream
//   curr_sn, err  : retired-word count and sticky error flags
// master drives the inputs of the packer; slave is the packer side.
interface probe_result_packer_if;
  logic             iss_valid;
  logic [7:0]       iss_mask;
  logic             iss_last;
  logic             iss_ready;

  logic [7:0]       res_valid;
  logic [7:0]       res_ready;
  logic [7:0][63:0] res_data;
  logic [7:0]       res_hit;
  logic [7:0][63:0] res_serialnum;

  logic [511:0]     out_data;
  logic [7:0]       out_keep;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  logic [31:0]      curr_sn;
  logic [1:0]       err;

  modport master (
    output iss_valid, iss_mask, iss_last,
    input  iss_ready,
    output res_valid, res_data, res_hit, res_serialnum,
    input  res_ready,
    input  out_data, out_keep, out_valid, out_last,
    output out_ready,
    input  curr_sn, err
  );

  modport slave (
    input  iss_valid, iss_mask, iss_last,
    output iss_ready,
    input  res_valid, res_data, res_hit, res_serialnum,
    output res_ready,
    output out_data, out_keep, out_valid, out_last,
    input  out_ready,
    output curr_sn, err
  );
endinterface

// File: rtl/probe_result_packer.sv
// Reorders per-lane probe results by serial number and packs them into 512-bit words.
//   clk, resetn : rising-edge clock, asynchronous active-low reset
//   bus (slave) : issue records in, eight result lanes in, packed word stream out,
//                 curr_sn (retired serial numbers) and sticky err flags out
// Results land in a reorder store indexed by serial number mod SLOTS. The head slot
// (curr_sn mod SLOTS) retires once every lane of its issue mask has delivered; hits
// are packed into the output register, misses are zeroed and dropped.
module probe_result_packer #(
  parameter int unsigned MAX_IN_TRANSIT = 2,
  parameter int unsigned SLOTS          = 2
) (
  input logic                  clk,
  input logic                  resetn,
  probe_result_packer_if.slave bus
);

  localparam int unsigned SlotW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CntW     = $clog2(SLOTS + 1);
  localparam logic [31:0] SlotMask = 32'(SLOTS - 1);
  localparam logic [31:0] Slots32  = 32'(SLOTS);

  if ((SLOTS < MAX_IN_TRANSIT) || ((SLOTS & (SLOTS - 1)) != 0)) begin : gen_cfg_check
    $error("SLOTS must be a power of two and >= MAX_IN_TRANSIT");
  end

  typedef logic [SlotW-1:0] slot_t;
  typedef enum logic [0:0] {StRun, StDone} state_e;

  function automatic slot_t slot_of(input logic [31:0] sn);
    return slot_t'(sn & SlotMask);
  endfunction

  state_e                       state_q, state_d;
  // Issue FIFO storage is indexed by slot: record for sn k lives at k mod SLOTS.
  logic [SLOTS-1:0][7:0]        mask_q, mask_d;
  logic [SLOTS-1:0]             last_q, last_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [SLOTS-1:0][7:0]        filled_q, filled_d;
  logic [SLOTS-1:0][7:0]        hit_q, hit_d;
  logic [SLOTS-1:0][7:0][63:0]  data_q, data_d;
  logic [SLOTS-1:0]             complete_q, complete_d;
  logic [31:0]                  curr_sn_q, curr_sn_d;
  logic [511:0]                 out_data_q, out_data_d;
  logic [7:0]                   out_keep_q, out_keep_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic [1:0]                   err_q, err_d;

  logic                         run, iss_ready, iss_push, retire, emit;
  slot_t                        head, wr_slot;
  logic [7:0]                   res_ready, head_keep;
  slot_t [7:0]                  lane_slot;
  logic [7:0][31:0]             lane_off;
  logic                         unused_lane_idx;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    last_d      = last_q;
    filled_d    = filled_q;
    hit_d       = hit_q;
    data_d      = data_q;
    curr_sn_d   = curr_sn_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;

    run       = (state_q == StRun);
    head      = slot_of(curr_sn_q);
    wr_slot   = slot_of(curr_sn_q + 32'(cnt_q));
    iss_ready = run && (cnt_q != CntW'(SLOTS));
    iss_push  = bus.iss_valid && iss_ready;
    // complete_q lags the store by one cycle; that stage sets the fill-to-output latency.
    retire    = run && complete_q[head] && (!out_valid_q || bus.out_ready);
    head_keep = hit_q[head] & mask_q[head];
    emit      = (head_keep != 8'h00) || last_q[head];

    // Result fills. Out-of-window and known out-of-mask results are dropped.
    for (int i = 0; i < 8; i++) begin
      lane_slot[i] = slot_of(bus.res_serialnum[i][31:0]);
      lane_off[i]  = bus.res_serialnum[i][31:0] - curr_sn_q;
      res_ready[i] = run && !filled_q[lane_slot[i]][i];
      if (bus.res_valid[i] && res_ready[i]) begin
        if (lane_off[i] >= Slots32) begin
          err_d[1] = 1'b1;
        end else if ((lane_off[i] < 32'(cnt_q)) && !mask_q[lane_slot[i]][i]) begin
          err_d[0] = 1'b1;
        end else begin
          filled_d[lane_slot[i]][i] = 1'b1;
          hit_d[lane_slot[i]][i]    = bus.res_hit[i];
          data_d[lane_slot[i]][i]   = bus.res_data[i];
        end
      end
    end

    if (iss_push) begin
      mask_d[wr_slot] = bus.iss_mask;
      last_d[wr_slot] = bus.iss_last;
    end

    if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (retire) begin
      // Lanes that filled before their record was issued are checked here.
      if ((filled_q[head] & ~mask_q[head]) != 8'h00) begin
        err_d[0] = 1'b1;
      end
      filled_d[head] = '0;
      hit_d[head]    = '0;
      curr_sn_d      = curr_sn_q + 32'd1;
      if (emit) begin
        out_valid_d = 1'b1;
        out_keep_d  = head_keep;
        out_last_d  = last_q[head];
        for (int i = 0; i < 8; i++) begin
          out_data_d[64*i +: 64] = head_keep[i] ? data_q[head][i] : 64'd0;
        end
      end
      if (last_q[head]) begin
        state_d = StDone;
      end
    end

    cnt_d = cnt_q + CntW'(iss_push) - CntW'(retire);

    // A slot is complete when its record exists and every masked lane has filled.
    // The slot retiring this cycle is forced clear so the lagged flag never goes stale.
    for (int s = 0; s < SLOTS; s++) begin
      complete_d[s] = (32'(slot_t'(slot_t'(s) - head)) < 32'(cnt_q)) &&
                      ((filled_q[s] & mask_q[s]) == mask_q[s]) &&
                      !(retire && (slot_t'(s) == head));
    end

    unused_lane_idx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      unused_lane_idx = unused_lane_idx ^ (^bus.res_serialnum[i][63:32]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StRun;
      mask_q      <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      filled_q    <= '0;
      hit_q       <= '0;
      data_q      <= '0;
      complete_q  <= '0;
      curr_sn_q   <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      filled_q    <= filled_d;
      hit_q       <= hit_d;
      data_q      <= data_d;
      complete_q  <= complete_d;
      curr_sn_q   <= curr_sn_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign bus.iss_ready = iss_ready;
  assign bus.res_ready = res_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.curr_sn   = curr_sn_q;
  assign bus.err       = err_q;

endmodule
